// File: rtl/phaser_prog.sv
// Programmable PHI2 generator for a 65C02: stretchable low/high phases, a run/stop
// point in the low phase, wait-state extension of the high phase and bus-control strobes.
module phaser_prog #(
  parameter int CNT_W = 4,
  parameter int EXT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic [CNT_W-1:0] lo_len,
  input  logic [CNT_W-1:0] hi_len,
  input  logic [EXT_W-1:0] ext_cnt,
  input  logic             ext_hold,
  output logic             cphi2,
  output logic             stopped,
  output logic             latch_ad,
  output logic             setup_cs,
  output logic             release_wr,
  output logic             release_cs,
  output logic [CNT_W-1:0] phase_cnt
);

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    HIGH = 2'd1,
    EXT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(3);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_t           st, nxt_st;
  logic [CNT_W-1:0] cnt, nxt_cnt, len_l, len_h;
  logic [EXT_W-1:0] ext_r, nxt_ext, ext_dec;
  logic             latch_len, nxt_stopped, nxt_ad, nxt_wr, nxt_cs;

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
    return (v < MIN_LEN) ? MIN_LEN : v;
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    nxt_st      = st;
    nxt_cnt     = cnt;
    nxt_ext     = ext_r;
    latch_len   = 1'b0;
    nxt_stopped = 1'b0;
    nxt_ad      = 1'b0;
    nxt_wr      = 1'b0;
    nxt_cs      = 1'b0;
    ext_dec     = (ext_r != '0) ? ext_r - EXT_W'(1) : '0;

    case (st)
      LOW: begin
        if (cnt == ONE && !run) begin
          nxt_stopped = 1'b1;
        end else if (cnt == ONE) begin
          nxt_cnt = TWO;
          nxt_ad  = 1'b1;
        end else if (cnt == len_l - ONE) begin
          nxt_st  = HIGH;
          nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt + ONE;
        end
      end
      HIGH: begin
        if (cnt == '0) nxt_ext = ext_cnt;
        if (cnt == len_h - ONE) begin
          nxt_st    = LOW;
          nxt_cnt   = '0;
          nxt_cs    = 1'b1;
          latch_len = 1'b1;
        end else if (cnt == len_h - TWO) begin
          if (ext_r != '0 || ext_hold) begin
            nxt_st = EXT;
          end else begin
            nxt_cnt = len_h - ONE;
            nxt_wr  = 1'b1;
          end
        end else begin
          nxt_cnt = cnt + ONE;
        end
      end
      EXT: begin
        // Exit decision uses the post-decrement count so ext_cnt adds exactly ext_cnt clks.
        nxt_ext = ext_dec;
        if (ext_dec == '0 && !ext_hold) begin
          nxt_st  = HIGH;
          nxt_cnt = len_h - ONE;
          nxt_wr  = 1'b1;
        end
      end
      default: begin
        nxt_st  = LOW;
        nxt_cnt = '0;
        nxt_ext = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st         <= LOW;
      cnt        <= '0;
      ext_r      <= '0;
      len_l      <= clamp_len(lo_len);
      len_h      <= clamp_len(hi_len);
      cphi2      <= 1'b0;
      stopped    <= 1'b0;
      latch_ad   <= 1'b0;
      setup_cs   <= 1'b0;
      release_wr <= 1'b0;
      release_cs <= 1'b0;
    end else begin
      st         <= nxt_st;
      cnt        <= nxt_cnt;
      ext_r      <= nxt_ext;
      cphi2      <= (nxt_st == HIGH) || (nxt_st == EXT);
      stopped    <= nxt_stopped;
      latch_ad   <= nxt_ad;
      setup_cs   <= nxt_ad;
      release_wr <= nxt_wr;
      release_cs <= nxt_cs;
      if (latch_len) begin
        len_l <= clamp_len(lo_len);
        len_h <= clamp_len(hi_len);
      end
    end
  end

  assign phase_cnt = cnt;

endmodule

// File: tb/tb_phaser_prog.sv
// Scoreboard bench for phaser_prog: stimulus pushes expected phase lengths per CPU
// cycle, a negedge monitor measures each completed cycle and compares.
module tb_phaser_prog;

  localparam int CNT_W = 4;
  localparam int EXT_W = 2;
  localparam int WAIT_LIMIT = 200;

  logic             clk = 1'b0;
  logic             resetn;
  logic             run;
  logic [CNT_W-1:0] lo_len, hi_len;
  logic [EXT_W-1:0] ext_cnt;
  logic             ext_hold;
  logic             cphi2, stopped, latch_ad, setup_cs, release_wr, release_cs;
  logic [CNT_W-1:0] phase_cnt;

  phaser_prog #(.CNT_W(CNT_W), .EXT_W(EXT_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .run        (run),
    .lo_len     (lo_len),
    .hi_len     (hi_len),
    .ext_cnt    (ext_cnt),
    .ext_hold   (ext_hold),
    .cphi2      (cphi2),
    .stopped    (stopped),
    .latch_ad   (latch_ad),
    .setup_cs   (setup_cs),
    .release_wr (release_wr),
    .release_cs (release_cs),
    .phase_cnt  (phase_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lo;
    int hi;
    int stop;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_l, cur_h;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int max3(input int v);
    return (v < 3) ? 3 : v;
  endfunction

  // Monitor: measure each cycle from one cphi2 fall to the next.
  initial begin
    int   low_n, high_n, stop_n, latch_n, setup_n, latch_at, wr_n, wr_last, cs_stray;
    bit   prev_c;
    exp_t e;
    low_n = 0; high_n = 0; stop_n = 0; latch_n = 0; setup_n = 0;
    latch_at = 0; wr_n = 0; wr_last = 0; cs_stray = 0; prev_c = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        low_n = 0; high_n = 0; stop_n = 0; latch_n = 0; setup_n = 0;
        latch_at = 0; wr_n = 0; wr_last = 0; cs_stray = 0; prev_c = 1'b0;
        continue;
      end
      if (!cphi2) begin
        if (prev_c) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("low_len", low_n, e.lo);
            check("high_len", high_n, e.hi);
            check("stop_clks", stop_n, e.stop);
            check("latch_ad_cnt", latch_n, 1);
            check("setup_cs_cnt", setup_n, 1);
            check("latch_pos", latch_at, e.stop + 3);
            check("release_wr_cnt", wr_n, 1);
            check("release_wr_last_high", wr_last, 1);
            check("release_cs_at_fall", int'(release_cs), 1);
            check("release_cs_stray", cs_stray, 0);
            check("cnt_at_fall", int'(phase_cnt), 0);
          end
          low_n = 1; high_n = 0; stop_n = 0; latch_n = 0; setup_n = 0;
          latch_at = 0; wr_n = 0; wr_last = 0; cs_stray = 0;
        end else begin
          low_n++;
          if (release_cs) cs_stray++;
        end
        if (stopped) begin
          stop_n++;
          check("cnt_at_stop", int'(phase_cnt), 1);
        end
        if (latch_ad) begin
          latch_n++;
          latch_at = low_n;
        end
        if (setup_cs) setup_n++;
        if (release_wr) wr_n++;
      end else begin
        if (!prev_c) begin
          high_n = 1;
          check("cnt_at_rise", int'(phase_cnt), 0);
        end else begin
          high_n++;
        end
        wr_last = int'(release_wr);
        if (release_wr) wr_n++;
        if (release_cs) cs_stray++;
        if (latch_ad) latch_n++;
        if (setup_cs) setup_n++;
      end
      prev_c = cphi2;
    end
  end

  // Bounded wait for a cphi2 rise (rise=1) or fall (rise=0); returns just after the edge.
  task automatic wait_edge(input bit rise, input string name);
    bit last;
    last = cphi2;
    for (int n = 1; n <= WAIT_LIMIT; n++) begin
      @(posedge clk);
      #1;
      if (rise ? (!last && cphi2) : (last && !cphi2)) return;
      last = cphi2;
    end
    checks++;
    failures++;
    $display("FAIL timeout_%s waited=%0d limit=%0d", name, WAIT_LIMIT, WAIT_LIMIT);
  endtask

  // Drive one CPU cycle starting at LOW cnt=0; the new lengths take effect next cycle.
  task automatic run_cycle(input int lo_new, input int hi_new, input int ext_new,
                           input int hold_n, input int stop_n, input bit glitch);
    exp_t e;
    ext_cnt  = EXT_W'(ext_new);
    e.lo     = cur_l + stop_n;
    e.hi     = cur_h + ext_new + hold_n;
    e.stop   = stop_n;
    sb.push_back(e);
    ext_hold = glitch;
    if (stop_n > 0) begin
      run = 1'b0;
      repeat (stop_n + 1) @(posedge clk);
      #1;
      run = 1'b1;
    end else if (glitch) begin
      run = 1'b0;
      @(posedge clk);
      #1;
      run = 1'b1;
    end
    ext_hold = 1'b0;
    lo_len   = CNT_W'($urandom);
    hi_len   = CNT_W'($urandom);
    wait_edge(1'b1, "rise");
    lo_len = CNT_W'(lo_new);
    hi_len = CNT_W'(hi_new);
    if (hold_n > 0) begin
      @(posedge clk);
      #1;
      ext_hold = 1'b1;
      repeat (hold_n) @(posedge clk);
      #1;
      ext_hold = 1'b0;
    end
    cur_l = max3(lo_new);
    cur_h = max3(hi_new);
    wait_edge(1'b0, "fall");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog elapsed=%0t limit=2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_r, hi_r, ext_r, hold_r, stop_r;
    resetn   = 1'b0;
    run      = 1'b1;
    lo_len   = CNT_W'(5);
    hi_len   = CNT_W'(4);
    ext_cnt  = '0;
    ext_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cphi2", int'(cphi2), 0);
    check("rst_stopped", int'(stopped), 0);
    check("rst_latch_ad", int'(latch_ad), 0);
    check("rst_setup_cs", int'(setup_cs), 0);
    check("rst_release_wr", int'(release_wr), 0);
    check("rst_release_cs", int'(release_cs), 0);
    check("rst_phase_cnt", int'(phase_cnt), 0);
    cur_l = 5;
    cur_h = 4;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset-latched 5/4 cycle, then default 3/3 cycles.
    repeat (4) run_cycle(3, 3, 0, 0, 0, 1'b0);
    run_cycle(5, 7, 0, 0, 0, 1'b0);
    run_cycle(1, 1, 0, 0, 0, 1'b1);
    run_cycle(3, 3, 0, 0, 0, 1'b0);
    run_cycle(3, 3, 2, 0, 0, 1'b0);
    run_cycle(3, 3, 0, 10, 0, 1'b0);
    run_cycle(3, 3, 0, 0, 8, 1'b0);

    for (int i = 0; i < 20; i++) begin
      lo_r   = int'($urandom_range(0, 15));
      hi_r   = int'($urandom_range(0, 15));
      ext_r  = int'($urandom_range(0, 3));
      hold_r = (cur_h == 3 && ext_r == 0 && $urandom_range(0, 1) == 1) ?
               int'($urandom_range(1, 5)) : 0;
      stop_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_cycle(lo_r, hi_r, ext_r, hold_r, stop_r, 1'($urandom_range(0, 1)));
    end

    // Reset while stretched in the extension state.
    run_cycle(3, 3, 0, 0, 0, 1'b0);
    ext_cnt = EXT_W'(3);
    wait_edge(1'b1, "rise_ext");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("ext_cphi2", int'(cphi2), 1);
    check("ext_cnt_held", int'(phase_cnt), 1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("ext_rst_cphi2", int'(cphi2), 0);
    check("ext_rst_release_wr", int'(release_wr), 0);
    check("ext_rst_release_cs", int'(release_cs), 0);
    check("ext_rst_latch_ad", int'(latch_ad), 0);
    check("ext_rst_stopped", int'(stopped), 0);
    check("ext_rst_phase_cnt", int'(phase_cnt), 0);
    sb.delete();
    ext_cnt = '0;
    lo_len  = CNT_W'(3);
    hi_len  = CNT_W'(3);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cur_l  = 3;
    cur_h  = 3;
    repeat (2) run_cycle(3, 3, 0, 0, 0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
